// File: rtl/dmem_responder.sv
// Data-memory responder: latency-configurable byte/half/word RAM with error reporting.
// Optional DMEM_MISALIGN_ERR_EN turns misaligned half/word accesses into errors.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_rd_en_i,
  input  logic        req_wr_en_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam bit ZL = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] q_addr, q_wdata;
  logic [1:0]  q_size;
  logic        q_rd, q_wr, q_sign;
  logic        accept, access;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   a_addr, a_wdata, rword, wd, ld;
  logic [1:0]    a_size;
  logic          a_rd, a_wr, a_sign, a_err;
  logic [AW-1:0] a_idx;
  logic [3:0]    be;
  logic [7:0]    b8;
  logic [15:0]   h16;

  assign req_ready_o = (state == IDLE) || (state == RESP);
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state == RESP);
  assign busy_o      = (state == WAIT) || ((state == RESP) && accept);

  // Zero latency accesses the RAM on the accept edge, so use live fields.
  assign a_addr  = ZL ? req_addr_i  : q_addr;
  assign a_wdata = ZL ? req_wdata_i : q_wdata;
  assign a_size  = ZL ? req_size_i  : q_size;
  assign a_rd    = ZL ? req_rd_en_i : q_rd;
  assign a_wr    = ZL ? req_wr_en_i : q_wr;
  assign a_sign  = ZL ? req_sign_i  : q_sign;
  assign access  = ZL ? accept : ((state == WAIT) && (cnt == 4'd1));
  assign a_idx   = a_addr[AW+1:2];

  always_comb begin
    a_err = (a_rd == a_wr) || (a_size == 2'b11) ||
            (a_addr[31:2] >= 30'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_ERR_EN
    a_err = a_err || ((a_size == 2'b01) && a_addr[0]) ||
            ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
`endif
  end

  always_comb begin
    be = 4'b1111;
    wd = a_wdata;
    unique case (1'b1)
      a_size == 2'b00: begin
        be = 4'b0001 << a_addr[1:0];
        wd = {4{a_wdata[7:0]}};
      end
      a_size == 2'b01: begin
        be = a_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{a_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    rword = mem[a_idx];
    b8    = rword[{a_addr[1:0], 3'b000} +: 8];
    h16   = a_addr[1] ? rword[31:16] : rword[15:0];
    ld    = rword;
    unique case (1'b1)
      a_size == 2'b00:
        ld = a_sign ? {24'b0, b8} : {{24{b8[7]}}, b8};
      a_size == 2'b01:
        ld = a_sign ? {16'b0, h16} : {{16{h16[15]}}, h16};
      default: ld = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (access && rst_ni && a_wr && !a_err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[a_idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      q_addr      <= '0;
      q_wdata     <= '0;
      q_size      <= 2'b00;
      q_rd        <= 1'b0;
      q_wr        <= 1'b0;
      q_sign      <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (accept) begin
        q_addr  <= req_addr_i;
        q_wdata <= req_wdata_i;
        q_size  <= req_size_i;
        q_rd    <= req_rd_en_i;
        q_wr    <= req_wr_en_i;
        q_sign  <= req_sign_i;
      end
      if (access) begin
        rsp_rdata_o <= (a_err || !a_rd) ? 32'h0 : ld;
        rsp_err_o   <= a_err;
      end
      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            state <= ZL ? RESP : WAIT;
            cnt   <= 4'(LATENCY);
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: LATENCY=0 and LATENCY=1 responders share request fields.
// Expected responses are queued at issue and checked by per-DUT monitors.
module tb_dmem_responder;
  localparam int DW = 64;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid0, valid1;
  logic [31:0] addr, wdata;
  logic        rd_en, wr_en, sign;
  logic [1:0]  size;
  logic        ready0, ready1, rv0, rv1, err0, err1, busy0, busy1;
  logic [31:0] rdata0, rdata1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_b2b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(0)) u0 (
    .clk(clk), .rst_ni(rst_ni),
    .req_valid_i(valid0), .req_ready_o(ready0),
    .req_addr_i(addr), .req_rd_en_i(rd_en), .req_wr_en_i(wr_en),
    .req_size_i(size), .req_sign_i(sign), .req_wdata_i(wdata),
    .rsp_valid_o(rv0), .rsp_rdata_o(rdata0), .rsp_err_o(err0),
    .busy_o(busy0)
  );

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(1)) u1 (
    .clk(clk), .rst_ni(rst_ni),
    .req_valid_i(valid1), .req_ready_o(ready1),
    .req_addr_i(addr), .req_rd_en_i(rd_en), .req_wr_en_i(wr_en),
    .req_size_i(size), .req_sign_i(sign), .req_wdata_i(wdata),
    .rsp_valid_o(rv1), .rsp_rdata_o(rdata1), .rsp_err_o(err1),
    .busy_o(busy1)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input bit d, input logic [31:0] rd, input logic er);
    exp_t e;
    if (d == 1'b0) begin
      if (q0.size() == 0) begin
        check("u0 unexpected rsp", 32'd1, 32'd0);
        return;
      end
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) begin
        check("u1 unexpected rsp", 32'd1, 32'd0);
        return;
      end
      e = q1.pop_front();
    end
    check($sformatf("u%0d rdata", d), rd, e.rd);
    check($sformatf("u%0d err", d), {31'b0, er}, {31'b0, e.er});
    check($sformatf("u%0d rsp cycle", d), cyc, e.due);
  endtask

  always @(posedge clk) begin
    #1;
    if (rv0) mon(1'b0, rdata0, err0);
    if (rv1) mon(1'b1, rdata1, err1);
  end

  task automatic send(input bit d, input logic r, input logic w,
                      input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] xrd, input logic xer,
                      input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    rd_en = r; wr_en = w; size = sz; sign = sg; addr = a; wdata = wd;
    if (d) valid1 = 1'b1; else valid0 = 1'b1;
    if (chk_b2b) begin
      check("b2b ready", {31'b0, ready0}, 32'd1);
      check("b2b busy", {31'b0, busy0}, 32'd1);
    end
    while (!(d ? ready1 : ready0)) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        check("ready timeout", 32'd0, 32'd1);
        return;
      end
    end
    e.rd  = xrd;
    e.er  = xer;
    e.due = cyc + 1 + (d ? 1 : 0);
    if (push) begin
      if (d) q1.push_back(e); else q0.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    check({nm, " ready0"}, {31'b0, ready0}, 32'd1);
    check({nm, " ready1"}, {31'b0, ready1}, 32'd1);
    check({nm, " valid"}, {30'b0, rv1, rv0}, 32'd0);
    check({nm, " err"}, {30'b0, err1, err0}, 32'd0);
    check({nm, " busy"}, {30'b0, busy1, busy0}, 32'd0);
    check({nm, " rdata1"}, rdata1, 32'd0);
    check({nm, " rdata0"}, rdata0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    addr = '0; wdata = '0; rd_en = 1'b0; wr_en = 1'b0;
    size = 2'b00; sign = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // u1, LATENCY=1
    send(1, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    send(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
    send(1, 0, 1, 2'b00, 0, 32'h13, 32'hABCDEF80, 32'h0, 0, 1);
    send(1, 1, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 1);
    send(1, 1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0, 1);
    send(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 1);
`ifdef DMEM_MISALIGN_ERR_EN
    send(1, 1, 0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1, 1);
    send(1, 1, 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 1);
`else
    send(1, 1, 0, 2'b01, 0, 32'h11, 32'h0, 32'hFFFFBEEF, 0, 1);
    send(1, 1, 0, 2'b10, 0, 32'h12, 32'h0, 32'h80ADBEEF, 0, 1);
`endif
    send(1, 0, 1, 2'b10, 0, 32'h0, 32'h12345678, 32'h0, 0, 1);
    send(1, 0, 1, 2'b10, 0, 32'h100, 32'hFFFFFFFF, 32'h0, 1, 1);
    send(1, 1, 1, 2'b10, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    send(1, 0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    send(1, 1, 0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    send(1, 1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h12345678, 0, 1);
    send(1, 0, 1, 2'b10, 0, 32'h4, 32'h01020304, 32'h0, 0, 1);
    send(1, 0, 1, 2'b01, 0, 32'h6, 32'h5555CAFE, 32'h0, 0, 1);
    send(1, 1, 0, 2'b01, 1, 32'h6, 32'h0, 32'h0000CAFE, 0, 1);
    send(1, 1, 0, 2'b10, 0, 32'h4, 32'h0, 32'hCAFE0304, 0, 1);
    send(1, 1, 0, 2'b01, 0, 32'h4, 32'h0, 32'h00000304, 0, 1);
    send(1, 1, 0, 2'b00, 0, 32'h7, 32'h0, 32'hFFFFFFCA, 0, 1);
    send(1, 1, 0, 2'b00, 1, 32'h5, 32'h0, 32'h00000003, 0, 1);
    send(1, 0, 1, 2'b10, 0, 32'hFC, 32'h0BADF00D, 32'h0, 0, 1);
    send(1, 1, 0, 2'b10, 0, 32'hFC, 32'h0, 32'h0BADF00D, 0, 1);

    // reset while a store sits in WAIT
    send(1, 0, 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0, 1);
    send(1, 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0, 1);
    send(1, 0, 1, 2'b10, 0, 32'h20, 32'hAAAAAAAA, 32'h0, 0, 0);
    #2;
    rst_ni = 1'b0;
    valid1 = 1'b0;
    #1;
    chk_reset("midop");
    repeat (2) @(negedge clk);
    chk_reset("midop hold");
    rst_ni = 1'b1;
    send(1, 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0, 1);
    idle(4);

    // u0, LATENCY=0 back-to-back
    send(0, 0, 1, 2'b10, 0, 32'h40, 32'h11111111, 32'h0, 0, 1);
    chk_b2b = 1'b1;
    send(0, 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11111111, 0, 1);
    send(0, 0, 1, 2'b00, 0, 32'h41, 32'h00000022, 32'h0, 0, 1);
    send(0, 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11112211, 0, 1);
    send(0, 1, 0, 2'b01, 0, 32'h42, 32'h0, 32'h00001111, 0, 1);
    send(0, 1, 0, 2'b00, 1, 32'h41, 32'h0, 32'h00000022, 0, 1);
    send(0, 1, 0, 2'b01, 0, 32'h40, 32'h0, 32'h00002211, 0, 1);
    send(0, 0, 1, 2'b10, 0, 32'h100, 32'h0, 32'h0, 1, 1);
    chk_b2b = 1'b0;
    idle(6);

    check("q0 drained", q0.size(), 32'd0);
    check("q1 drained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the far end of the pipeline's load/store interface. It accepts one memory request per handshake from the MA stage, performs a byte/half/word read or write to an internal word-organised RAM after a configurable latency, and returns a single-cycle response carrying the extended load data or an error flag. While a request is outstanding, `busy_o` drives the hazard unit's MA stall.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- `LATENCY`, 1: wait cycles between acceptance and RAM access; range 0..15.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  responder can accept this cycle.
- `req_addr_i`  in  32  byte address (ALU result).
- `req_rd_en_i`  in  1  load.
- `req_wr_en_i`  in  1  store.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_sign_i`  in  1  1 = zero-extend load (func3[2]); 0 = sign-extend.
- `req_wdata_i`  in  32  store data, right-justified.
- `rsp_valid_o`  out  1  response valid, one cycle.
- `rsp_rdata_o`  out  32  extended load data; 0 for stores and errors.
- `rsp_err_o`  out  1  request rejected; no RAM side effect.
- `busy_o`  out  1  request accepted and response not yet delivered.

## Operation
- States: IDLE, WAIT, RESP.
- `req_ready_o` = state is IDLE or RESP. Accept = `req_valid_i && req_ready_o`; all request fields are registered on accept.
- On accept: go to WAIT with count = LATENCY. If LATENCY = 0, go directly to RESP.
- WAIT: decrement count each cycle. At count 1 → RESP, performing the RAM access on that edge.
- RESP: `rsp_valid_o` = 1 for exactly this cycle. A new accept here → WAIT (or RESP if LATENCY = 0); otherwise → IDLE.
- Error conditions (any one sets `rsp_err_o`, suppresses the write, and forces rdata to 0):
  - `req_rd_en_i` == `req_wr_en_i` (both or neither);
  - size 11;
  - word index `req_addr_i[31:2]` ≥ DEPTH_WORDS;
  - misalignment (see Configuration).
- Store lanes:
  - byte: lane `addr[1:0]` ← wdata[7:0];
  - half: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0];
  - word: all four lanes. Unwritten lanes are unchanged.
- Load:
  - select byte/half from the word at `addr[1:0]`/`addr[1]`;
  - `req_sign_i` = 0 sign-extends to 32 bits, 1 zero-extends;
  - word loads are returned unmodified.
- `rsp_rdata_o` and `rsp_err_o` hold their value outside RESP. Consumers qualify them only with `rsp_valid_o`.
- `busy_o` = (state ≠ IDLE) and not (state == RESP with no new accept).

## Timing
- Accept at edge N. RAM access and `rsp_valid_o` high in cycle N+1+LATENCY. Write is committed at that edge.
- Throughput: one request per LATENCY+1 cycles with back-to-back accepts in RESP.
- Reset values: state IDLE, count 0; `req_ready_o` 1; `rsp_valid_o` 0; `rsp_rdata_o` 0; `rsp_err_o` 0; `busy_o` 0. RAM contents are not reset.
- Reset asserted mid-operation: the pending request is dropped, an uncommitted store never writes, and no response is issued.
- Read-after-write to the same address in consecutive requests returns the new data (the write commits before the next access).
- `req_*` inputs are ignored when not accepted.

## Configuration
- `DMEM_MISALIGN_ERR_EN` defined: a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, is an error as above.
- Undefined: alignment is never an error. Half accesses ignore addr[0]; word accesses ignore addr[1:0]. The access is performed at the forced-aligned location.

## Test plan
- LATENCY=1: store word 0xDEADBEEF at 0x10, then load word 0x10 → `rsp_valid_o` 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
- Store byte 0x80 at 0x13, then load byte 0x13 with sign=0 → 0xFFFFFF80. With sign=1 → 0x00000080. Load word 0x10 → 0x80ADBEEF.
- Load half at 0x11:
  - with `DMEM_MISALIGN_ERR_EN` → err 1, rdata 0;
  - without it → returns the half at 0x10 (0xBEEF, sign-extended to 0xFFFFBEEF).
- Store to `4*DEPTH_WORDS`, or `rd_en`=`wr_en`=1 → err 1. A subsequent load of word 0 returns its previous value.
- LATENCY=0, back-to-back valid requests → `req_ready_o` never drops, one response per cycle, `busy_o` stays 1.
- `rst_ni` pulsed low in WAIT of a store to 0x20 → no response. A later load of 0x20 returns the pre-store value. Outputs read reset values during reset.
